// File: rtl/canvas_pkg.sv
// Shared definitions for the 28x28 drawing canvas: geometry, brush increments,
// saturation ceiling, index/pixel types and the painter state encoding.
package canvas_pkg;

    localparam int CELL_PX = 14;
    localparam int GRID    = 28;

    localparam logic [15:0] CENTER_INC = 16'h0400;
    localparam logic [15:0] EDGE_INC   = 16'h0100;
    localparam logic [15:0] MAX_VAL    = 16'h0FF0;

    typedef logic [4:0]  cell_idx_t;
    typedef logic [15:0] pixel_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOCATE,
        ST_READ,
        ST_WAIT,
        ST_WRITE
    } painter_state_t;

endpackage

// File: rtl/canvas_cell_locator.sv
// Maps a screen pixel coordinate to its canvas cell index using a compare ladder
// against multiples of CELL_PX, plus a flag saying whether the pixel is on the canvas.
module canvas_cell_locator
    import canvas_pkg::*;
(
    input  logic [9:0] i_pixel,
    output cell_idx_t  o_cell,
    output logic       o_in_range
);

    // The highest threshold passed wins; off-canvas pixels saturate at GRID-1.
    always_comb begin
        o_cell = '0;
        for (int i = 1; i < GRID; i++) begin
            if (i_pixel >= 10'(i * CELL_PX)) begin
                o_cell = 5'(i);
            end
        end
    end

    assign o_in_range = (i_pixel < 10'(GRID * CELL_PX));

endmodule

// File: rtl/canvas_painter.sv
// Canvas writer: on each frame tick either clears the whole canvas or paints a
// plus-shaped, saturating read-modify-write brush stroke at the cursor cell.
module canvas_painter
    import canvas_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [9:0]  BallX,
    input  logic [9:0]  BallY,
    input  logic        paint,
    input  logic        clear,
    output logic [4:0]  rd_col,
    output logic [4:0]  rd_row,
    input  logic [15:0] rd_data,
    output logic        wr_en,
    output logic [4:0]  wr_col,
    output logic [4:0]  wr_row,
    output logic [15:0] wr_data,
    output logic        busy
);

    function automatic pixel_t sat_add(input pixel_t a, input pixel_t b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s > {1'b0, MAX_VAL}) begin
            return MAX_VAL;
        end
        return s[15:0];
    endfunction

    // Neighbour index: 0 centre, 1 left, 2 right, 3 up, 4 down.
    function automatic cell_idx_t nbr_col(input logic [2:0] idx, input cell_idx_t c);
        case (idx)
            3'd1:    return c - 5'd1;
            3'd2:    return c + 5'd1;
            default: return c;
        endcase
    endfunction

    function automatic cell_idx_t nbr_row(input logic [2:0] idx, input cell_idx_t r);
        case (idx)
            3'd3:    return r - 5'd1;
            3'd4:    return r + 5'd1;
            default: return r;
        endcase
    endfunction

    logic           r_fc_s1;
    logic           r_fc_s2;
    logic           r_fc_s3;
    logic           w_tick;

    painter_state_t r_state;
    logic           r_clear_pend;
    cell_idx_t      r_cx;
    cell_idx_t      r_cy;
    logic [2:0]     r_nbr;
    cell_idx_t      r_rd_col;
    cell_idx_t      r_rd_row;
    logic           r_wr_en;
    cell_idx_t      r_wr_col;
    cell_idx_t      r_wr_row;
    pixel_t         r_wr_data;
    logic           r_busy;

    cell_idx_t      w_cx;
    cell_idx_t      w_cy;
    logic           w_x_in;
    logic           w_y_in;
    logic [4:0]     w_nbr_ok;
    logic           w_next_vld;
    logic [2:0]     w_next_idx;
    pixel_t         w_inc;

    canvas_cell_locator u_loc_x (
        .i_pixel    (BallX),
        .o_cell     (w_cx),
        .o_in_range (w_x_in)
    );

    canvas_cell_locator u_loc_y (
        .i_pixel    (BallY),
        .o_cell     (w_cy),
        .o_in_range (w_y_in)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_fc_s1 <= 1'b0;
            r_fc_s2 <= 1'b0;
            r_fc_s3 <= 1'b0;
        end else begin
            r_fc_s1 <= frame_clk;
            r_fc_s2 <= r_fc_s1;
            r_fc_s3 <= r_fc_s2;
        end
    end

    assign w_tick = r_fc_s2 & ~r_fc_s3;

    // Pick the next in-bounds neighbour after the current one; skipping is free.
    always_comb begin
        w_nbr_ok   = {r_cy != 5'(GRID - 1), r_cy != 5'd0,
                      r_cx != 5'(GRID - 1), r_cx != 5'd0, 1'b1};
        w_next_vld = 1'b0;
        w_next_idx = r_nbr;
        for (int i = 4; i >= 1; i--) begin
            if ((3'(i) > r_nbr) && w_nbr_ok[i]) begin
                w_next_vld = 1'b1;
                w_next_idx = 3'(i);
            end
        end
    end

    assign w_inc = (r_nbr == 3'd0) ? CENTER_INC : EDGE_INC;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state      <= ST_IDLE;
            r_clear_pend <= 1'b0;
            r_cx         <= '0;
            r_cy         <= '0;
            r_nbr        <= '0;
            r_rd_col     <= '0;
            r_rd_row     <= '0;
            r_wr_en      <= 1'b0;
            r_wr_col     <= '0;
            r_wr_row     <= '0;
            r_wr_data    <= '0;
            r_busy       <= 1'b0;
        end else begin
            if (clear) begin
                r_clear_pend <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_tick) begin
                        if (r_clear_pend || clear) begin
                            r_state      <= ST_CLEAR;
                            r_clear_pend <= 1'b0;
                            r_busy       <= 1'b1;
                            r_wr_en      <= 1'b1;
                            r_wr_col     <= '0;
                            r_wr_row     <= '0;
                            r_wr_data    <= '0;
                        end else if (paint && w_x_in && w_y_in) begin
                            r_state <= ST_LOCATE;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                // The write address doubles as the clear counter, column-major.
                ST_CLEAR: begin
                    if (r_wr_col == 5'(GRID - 1) && r_wr_row == 5'(GRID - 1)) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_wr_en <= 1'b0;
                    end else if (r_wr_row == 5'(GRID - 1)) begin
                        r_wr_col <= r_wr_col + 5'd1;
                        r_wr_row <= '0;
                    end else begin
                        r_wr_row <= r_wr_row + 5'd1;
                    end
                end
                ST_LOCATE: begin
                    r_cx     <= w_cx;
                    r_cy     <= w_cy;
                    r_nbr    <= '0;
                    r_rd_col <= w_cx;
                    r_rd_row <= w_cy;
                    r_state  <= ST_READ;
                end
                ST_READ: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_wr_en   <= 1'b1;
                    r_wr_col  <= r_rd_col;
                    r_wr_row  <= r_rd_row;
                    r_wr_data <= sat_add(rd_data, w_inc);
                    r_state   <= ST_WRITE;
                end
                ST_WRITE: begin
                    r_wr_en <= 1'b0;
                    if (w_next_vld) begin
                        r_nbr    <= w_next_idx;
                        r_rd_col <= nbr_col(w_next_idx, r_cx);
                        r_rd_row <= nbr_row(w_next_idx, r_cy);
                        r_state  <= ST_READ;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_wr_en <= 1'b0;
                end
            endcase
        end
    end

    assign rd_col  = r_rd_col;
    assign rd_row  = r_rd_row;
    assign wr_en   = r_wr_en;
    assign wr_col  = r_wr_col;
    assign wr_row  = r_wr_row;
    assign wr_data = r_wr_data;
    assign busy    = r_busy;

endmodule

// File: tb/tb_canvas_painter.sv
// Bench for canvas_painter: emulates the canvas storage, predicts every write from
// a cell-level model of the clear/brush rules and checks each write strobe.
module tb_canvas_painter;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_clk = 1'b0;
    logic [9:0]  BallX = '0;
    logic [9:0]  BallY = '0;
    logic        paint = 1'b0;
    logic        clear = 1'b0;
    logic [4:0]  rd_col;
    logic [4:0]  rd_row;
    logic [15:0] rd_data = '0;
    logic        wr_en;
    logic [4:0]  wr_col;
    logic [4:0]  wr_row;
    logic [15:0] wr_data;
    logic        busy;

    canvas_painter dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .BallX     (BallX),
        .BallY     (BallY),
        .paint     (paint),
        .clear     (clear),
        .rd_col    (rd_col),
        .rd_row    (rd_row),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_col    (wr_col),
        .wr_row    (wr_row),
        .wr_data   (wr_data),
        .busy      (busy)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int          c;
        int          r;
        logic [15:0] d;
    } wr_t;

    int          total = 0;
    int          bad = 0;
    logic [15:0] mem [0:31][0:31];
    int          model [0:27][0:27];
    bit          m_pend = 0;
    wr_t         expq [$];
    int          blen;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Canvas storage: 1-cycle read latency, synchronous write.
    always @(posedge Clk) begin
        rd_data <= mem[rd_col][rd_row];
        if (wr_en) mem[wr_col][wr_row] <= wr_data;
    end

    always @(negedge Clk) begin
        wr_t e;
        if (!Reset && wr_en) begin
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wr_unexpected: got col=%0d row=%0d data=%0h want no write",
                         wr_col, wr_row, wr_data);
            end else begin
                e = expq.pop_front();
                chk("wr", {6'd0, wr_col, wr_row, wr_data}, {6'd0, 5'(e.c), 5'(e.r), e.d});
            end
        end
    end

    function automatic int mcell(input int c, input int r, input int inc);
        wr_t e;
        if (c < 0 || c >= 28 || r < 0 || r >= 28) return 0;
        model[c][r] = (model[c][r] + inc > 'hFF0) ? 'hFF0 : model[c][r] + inc;
        e.c = c;
        e.r = r;
        e.d = 16'(model[c][r]);
        expq.push_back(e);
        return 1;
    endfunction

    task automatic tick_op(input bit mid_clear, input bit mid_tick, output int len);
        int exp_len, n, cx, cy, w;
        bit seen;
        exp_len = 0;
        if (m_pend) begin
            for (int c = 0; c < 28; c++)
                for (int r = 0; r < 28; r++) begin
                    model[c][r] = 0;
                    void'(mcell(c, r, 0));
                end
            exp_len = 784;
            m_pend = 0;
        end else if (paint && BallX < 392 && BallY < 392) begin
            cx = int'(BallX) / 14;
            cy = int'(BallY) / 14;
            n = mcell(cx, cy, 'h400);
            n += mcell(cx - 1, cy, 'h100);
            n += mcell(cx + 1, cy, 'h100);
            n += mcell(cx, cy - 1, 'h100);
            n += mcell(cx, cy + 1, 'h100);
            exp_len = 1 + 3 * n;
        end
        @(negedge Clk);
        frame_clk = 1'b1;
        len = 0;
        if (exp_len == 0) begin
            seen = 0;
            repeat (10) begin
                @(negedge Clk);
                if (busy) seen = 1;
            end
            chk("noop_busy", 32'(seen), 0);
        end else begin
            w = 0;
            while (!busy && w < 12) begin
                @(negedge Clk);
                w++;
            end
            chk("busy_start", 32'(busy), 1);
            while (busy && len < 2000) begin
                len++;
                clear = (mid_clear && len == 3);
                if (clear) m_pend = 1;
                if (len == 2) begin
                    BallX = 10'($urandom_range(0, 420));
                    BallY = 10'($urandom_range(0, 420));
                end
                if (mid_tick && len == 4) frame_clk = 1'b0;
                if (mid_tick && len == 8) frame_clk = 1'b1;
                @(negedge Clk);
            end
            clear = 1'b0;
            chk("busy_len", 32'(len), 32'(exp_len));
        end
        frame_clk = 1'b0;
        repeat (5) @(negedge Clk);
        if (mid_tick) chk("dropped_tick_busy", 32'(busy), 0);
    endtask

    task automatic pulse_clear();
        @(negedge Clk);
        clear = 1'b1;
        m_pend = 1;
        @(negedge Clk);
        clear = 1'b0;
    endtask

    task automatic check_canvas(input string nm);
        int mism;
        mism = 0;
        for (int c = 0; c < 28; c++)
            for (int r = 0; r < 28; r++)
                if (mem[c][r] !== 16'(model[c][r])) mism++;
        chk(nm, 32'(mism), 0);
    endtask

    initial begin
        int n;
        for (int c = 0; c < 32; c++)
            for (int r = 0; r < 32; r++) mem[c][r] = '0;
        for (int c = 0; c < 28; c++)
            for (int r = 0; r < 28; r++) model[c][r] = 0;

        // Reset state
        repeat (3) @(negedge Clk);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_wr_data", 32'(wr_data), 0);
        chk("rst_rd_addr", {22'd0, rd_col, rd_row}, 0);
        chk("rst_wr_addr", {22'd0, wr_col, wr_row}, 0);
        Reset = 1'b0;
        repeat (3) @(negedge Clk);

        // Idle ticks, brush up
        paint = 1'b0;
        BallX = 10'd140;
        BallY = 10'd70;
        repeat (3) tick_op(0, 0, blen);

        // Interior stroke
        paint = 1'b1;
        tick_op(0, 0, blen);
        chk("interior_busy16", 32'(blen), 16);
        chk("c10_5", 32'(mem[10][5]), 32'h0400);
        chk("c9_5", 32'(mem[9][5]), 32'h0100);
        chk("c11_5", 32'(mem[11][5]), 32'h0100);
        chk("c10_4", 32'(mem[10][4]), 32'h0100);
        chk("c10_6", 32'(mem[10][6]), 32'h0100);
        chk("c9_4_diag", 32'(mem[9][4]), 32'h0000);

        // Corner strokes and saturation
        BallX = 10'd0;
        BallY = 10'd0;
        tick_op(0, 0, blen);
        chk("corner_busy10", 32'(blen), 10);
        chk("sat1", 32'(mem[0][0]), 32'h0400);
        BallX = 10'd0; BallY = 10'd0;
        tick_op(0, 0, blen);
        chk("sat2", 32'(mem[0][0]), 32'h0800);
        BallX = 10'd0; BallY = 10'd0;
        tick_op(0, 0, blen);
        chk("sat3", 32'(mem[0][0]), 32'h0C00);
        BallX = 10'd0; BallY = 10'd0;
        tick_op(0, 0, blen);
        chk("sat4", 32'(mem[0][0]), 32'h0FF0);

        // Clear during a stroke, then the clear itself
        BallX = 10'd140; BallY = 10'd70;
        tick_op(1, 0, blen);
        chk("midclr_stroke16", 32'(blen), 16);
        tick_op(0, 0, blen);
        chk("clear_busy784", 32'(blen), 784);
        check_canvas("canvas_after_clear");

        // Tick during CLEAR dropped; clear wins over paint; off-canvas cursor
        pulse_clear();
        tick_op(0, 1, blen);
        paint = 1'b1; BallX = 10'd140; BallY = 10'd70;
        pulse_clear();
        tick_op(0, 0, blen);
        chk("clear_wins784", 32'(blen), 784);
        chk("clear_wins_cell", 32'(mem[10][5]), 0);
        BallX = 10'd392; BallY = 10'd70;
        tick_op(0, 0, blen);
        BallX = 10'd391; BallY = 10'd70;
        tick_op(0, 0, blen);
        chk("edge_busy13", 32'(blen), 13);
        chk("c27_5", 32'(mem[27][5]), 32'h0400);
        BallX = 10'd0; BallY = 10'd14;
        tick_op(0, 0, blen);

        // Reset at the 3rd write of a CLEAR
        pulse_clear();
        expq.push_back('{0, 0, 16'h0});
        expq.push_back('{0, 1, 16'h0});
        expq.push_back('{0, 2, 16'h0});
        @(negedge Clk);
        frame_clk = 1'b1;
        n = 0;
        for (int k = 0; k < 40 && n < 3; k++) begin
            @(negedge Clk);
            if (wr_en) n++;
        end
        chk("rst_mid_reached3", 32'(n), 3);
        #1;
        Reset = 1'b1;
        frame_clk = 1'b0;
        #1;
        chk("rst_mid_wr_en", 32'(wr_en), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        expq.delete();
        model[0][0] = 0;
        model[0][1] = 0;
        m_pend = 0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        repeat (4) @(negedge Clk);
        chk("rst_c0_0", 32'(mem[0][0]), 0);
        chk("rst_c0_1", 32'(mem[0][1]), 0);
        chk("rst_c0_2_kept", 32'(mem[0][2]), 32'h0100);
        chk("rst_c27_5_kept", 32'(mem[27][5]), 32'h0400);
        check_canvas("canvas_after_reset");

        // Randomized operations
        for (int it = 0; it < 30; it++) begin
            int sel;
            sel = int'($urandom_range(0, 11));
            if (sel == 0) pulse_clear();
            paint = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 4))
                0: begin BallX = 10'($urandom_range(0, 13)); BallY = 10'($urandom_range(378, 395)); end
                1: begin BallX = 10'($urandom_range(378, 395)); BallY = 10'($urandom_range(0, 13)); end
                default: begin BallX = 10'($urandom_range(0, 420)); BallY = 10'($urandom_range(0, 420)); end
            endcase
            tick_op(sel == 1, sel == 2, blen);
        end
        check_canvas("canvas_final");
        chk("queue_empty", 32'(expq.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
